// File: rtl/proc_mem_responder_if.sv
// Request/response bundle between the processor memory port (master)
// and the memory responder (slave).
interface proc_mem_responder_if;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [2:0]  memreq_type;
  logic [7:0]  memreq_opaque;
  logic [31:0] memreq_addr;
  logic [1:0]  memreq_len;
  logic [31:0] memreq_data;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [2:0]  memresp_type;
  logic [7:0]  memresp_opaque;
  logic [1:0]  memresp_len;
  logic [31:0] memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    input  memreq_rdy,
    input  memresp_val, memresp_type, memresp_opaque, memresp_len, memresp_data,
    output memresp_rdy
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    output memreq_rdy,
    output memresp_val, memresp_type, memresp_opaque, memresp_len, memresp_data,
    input  memresp_rdy
  );
endinterface

// File: rtl/proc_mem_responder.sv
// Single-outstanding memory responder: word/subword access to an internal
// word array, response after a fixed programmable latency.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | latency down-counter running, request held
// RESP  | response valid, held until memresp_rdy
module proc_mem_responder #(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 0
) (
  input  logic                clk,
  input  logic                reset,
  proc_mem_responder_if.slave mem
);
  localparam int         IDX_W   = $clog2(NUM_WORDS);
  localparam logic [7:0] LAT8    = 8'(LATENCY);
  localparam logic [2:0] TYPE_RD = 3'd0;
  localparam logic [2:0] TYPE_WR = 3'd1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       type_q, type_d;
  logic [7:0]       opaque_q, opaque_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic [1:0]       len_q, len_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      mem_q [NUM_WORDS];

  logic             acc_go;
  logic             acc_wr;
  logic [2:0]       acc_type;
  logic [IDX_W+1:0] acc_addr;
  logic [1:0]       acc_len;
  logic [31:0]      acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_off;
  logic [3:0]       len_mask;
  logic [3:0]       acc_be;
  logic [31:0]      len_bmask;
  logic [31:0]      acc_wshift;
  logic [31:0]      acc_rdata;
  logic             unused_addr_hi;

  // upper address bits alias onto the array
  assign unused_addr_hi = ^mem.memreq_addr[31:IDX_W+2];

  assign mem.memreq_rdy     = (state_q == IDLE) && !reset;
  assign mem.memresp_val    = (state_q == RESP);
  assign mem.memresp_type   = type_q;
  assign mem.memresp_opaque = opaque_q;
  assign mem.memresp_len    = len_q;
  assign mem.memresp_data   = rdata_q;

  // With zero latency the access happens on the accept edge, so it must
  // use the live request rather than the registered copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_type  = mem.memreq_type;
      acc_addr  = mem.memreq_addr[IDX_W+1:0];
      acc_len   = mem.memreq_len;
      acc_wdata = mem.memreq_data;
    end else begin
      acc_type  = type_q;
      acc_addr  = addr_q;
      acc_len   = len_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    acc_idx = acc_addr[IDX_W+1:2];
    acc_off = acc_addr[1:0];
    case (acc_len)
      2'd1:    len_mask = 4'b0001;
      2'd2:    len_mask = 4'b0011;
      2'd3:    len_mask = 4'b0111;
      default: len_mask = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      len_bmask[8*b +: 8] = {8{len_mask[b]}};
    end
    // 4-bit shift drops enables that would cross into the next word
    acc_be     = len_mask << acc_off;
    acc_wshift = acc_wdata << {acc_off, 3'b000};
    acc_rdata  = (mem_q[acc_idx] >> {acc_off, 3'b000}) & len_bmask;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    opaque_d = opaque_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    acc_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem.memreq_val && mem.memreq_rdy) begin
          type_d   = mem.memreq_type;
          opaque_d = mem.memreq_opaque;
          addr_d   = mem.memreq_addr[IDX_W+1:0];
          len_d    = mem.memreq_len;
          wdata_d  = mem.memreq_data;
          cnt_d    = LAT8;
          if (LAT8 == 8'd0) begin
            state_d = RESP;
            acc_go  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = RESP;
          acc_go  = 1'b1;
        end
      end
      RESP: begin
        if (mem.memresp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_go) rdata_d = (acc_type == TYPE_RD) ? acc_rdata : 32'd0;
  end

  // a write landing on the same edge reset rises is suppressed
  assign acc_wr = acc_go && (acc_type == TYPE_WR) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      type_q   <= '0;
      opaque_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wshift[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: three instances (latency 0, 3, 5) driven with
// directed and random requests, checked by a scoreboard against a byte-array model.
module tb_proc_mem_responder;
  localparam int NW = 256;
  localparam int NB = 4 * NW;

  typedef struct packed {
    logic [2:0]  t;
    logic [7:0]  op;
    logic [1:0]  l;
    logic [31:0] d;
  } resp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [2:0]       req_val, req_rdy, resp_val, resp_rdy;
  logic [2:0][2:0]  req_type, resp_type;
  logic [2:0][7:0]  req_opaque, resp_opaque;
  logic [2:0][31:0] req_addr, req_data, resp_data;
  logic [2:0][1:0]  req_len, resp_len;

  resp_t      exp_q [3][$];
  logic [7:0] mem_m [3][NB];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] prev_val, prev_rdy;
  resp_t      prev_f [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    proc_mem_responder_if ifc ();
    proc_mem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .mem   (ifc)
    );
    assign ifc.memreq_val    = req_val[g];
    assign ifc.memreq_type   = req_type[g];
    assign ifc.memreq_opaque = req_opaque[g];
    assign ifc.memreq_addr   = req_addr[g];
    assign ifc.memreq_len    = req_len[g];
    assign ifc.memreq_data   = req_data[g];
    assign ifc.memresp_rdy   = resp_rdy[g];
    assign req_rdy[g]        = ifc.memreq_rdy;
    assign resp_val[g]       = ifc.memresp_val;
    assign resp_type[g]      = ifc.memresp_type;
    assign resp_opaque[g]    = ifc.memresp_opaque;
    assign resp_len[g]       = ifc.memresp_len;
    assign resp_data[g]      = ifc.memresp_data;
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 3 : 5);
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endfunction

  // Byte-level reference: len bytes starting at the byte offset, clipped at the word end.
  function automatic resp_t model(input int g, input logic [2:0] t, input logic [7:0] op,
                                  input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    resp_t r;
    int n, base, off;
    n    = (l == 2'd0) ? 4 : int'(l);
    base = int'(a % 32'(NB)) & ~3;
    off  = int'(a % 32'd4);
    r.t = t; r.op = op; r.l = l; r.d = '0;
    for (int i = 0; i < n; i++) begin
      if (off + i < 4) begin
        if (t == 3'd1) mem_m[g][base+off+i] = d[8*i +: 8];
        else if (t == 3'd0) r.d[8*i +: 8] = mem_m[g][base+off+i];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] model_word(input int g, input int w);
    return {mem_m[g][4*w+3], mem_m[g][4*w+2], mem_m[g][4*w+1], mem_m[g][4*w]};
  endfunction

  task automatic issue(input int g, input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                       input logic [1:0] l, input logic [31:0] d, input bit discard,
                       input bit use_lit, input logic [31:0] lit, input bit hold_rdy, output bit ok);
    resp_t e;
    int n;
    @(posedge clk); #1;
    req_type[g] = t; req_opaque[g] = op; req_addr[g] = a; req_len[g] = l; req_data[g] = d;
    req_val[g] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_rdy[g] && n < 50);
    ok = req_rdy[g];
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: memreq_rdy 0 for %0d cycles, required 1", g, n);
      req_val[g] = 1'b0;
      return;
    end
    if (!discard) begin
      e = model(g, t, op, a, l, d);
      if (use_lit) e.d = lit;
      exp_q[g].push_back(e);
    end
    @(posedge clk); #1;
    req_val[g]    = 1'b0;
    req_type[g]   = 3'($urandom);
    req_opaque[g] = 8'($urandom);
    req_addr[g]   = $urandom;
    req_len[g]    = 2'($urandom);
    req_data[g]   = $urandom;
    resp_rdy[g]   = hold_rdy;
  endtask

  task automatic complete(input int g, input int stall);
    int lat;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_val[g] && lat < 300);
    chk($sformatf("accept_to_val_latency_dut%0d", g), 64'(lat), 64'(lat_of(g) + 1));
    if (!resp_val[g]) return;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 resp_rdy[g] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1 resp_rdy[g] = 1'b0;
    @(negedge clk);
    chk($sformatf("req_rdy_after_handshake_dut%0d", g), 64'(req_rdy[g]), 64'd1);
  endtask

  task automatic send(input int g, input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d, input int stall,
                      input bit use_lit, input logic [31:0] lit);
    bit ok;
    issue(g, t, op, a, l, d, 1'b0, use_lit, lit, stall == 0, ok);
    if (ok) complete(g, stall);
  endtask

  // Scoreboard monitor
  initial begin
    resp_t e;
    prev_val = '0;
    prev_rdy = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!reset) begin
          chk($sformatf("rdy_val_exclusive_dut%0d", g), 64'(req_rdy[g] & resp_val[g]), 64'd0);
          if (resp_val[g] && prev_val[g] && !prev_rdy[g])
            chk($sformatf("stall_stable_dut%0d", g),
                64'({resp_type[g], resp_opaque[g], resp_len[g], resp_data[g]}), 64'(prev_f[g]));
          if (resp_val[g] && resp_rdy[g]) begin
            if (exp_q[g].size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp dut%0d: response opaque=%0h with none outstanding",
                       g, resp_opaque[g]);
            end else begin
              e = exp_q[g].pop_front();
              chk($sformatf("resp_type_dut%0d", g), 64'(resp_type[g]), 64'(e.t));
              chk($sformatf("resp_opaque_dut%0d", g), 64'(resp_opaque[g]), 64'(e.op));
              chk($sformatf("resp_len_dut%0d", g), 64'(resp_len[g]), 64'(e.l));
              chk($sformatf("resp_data_dut%0d", g), 64'(resp_data[g]), 64'(e.d));
            end
          end
        end
        prev_val[g] = resp_val[g] && !reset;
        prev_rdy[g] = resp_rdy[g];
        prev_f[g]   = {resp_type[g], resp_opaque[g], resp_len[g], resp_data[g]};
      end
    end
  end

  initial begin
    logic [31:0] w104, prior, a;
    logic [7:0]  w;
    logic [2:0]  t;
    bit          ok;
    int          n, r;
    req_val = '0; resp_rdy = '0; req_type = '0; req_opaque = '0;
    req_addr = '0; req_len = '0; req_data = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_req_rdy_dut%0d", g), 64'(req_rdy[g]), 64'd0);
      chk($sformatf("reset_resp_val_dut%0d", g), 64'(resp_val[g]), 64'd0);
      chk($sformatf("reset_resp_fields_dut%0d", g),
          64'({resp_type[g], resp_opaque[g], resp_len[g], resp_data[g]}), 64'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("req_rdy_after_reset_dut%0d", g), 64'(req_rdy[g]), 64'd1);

    // known contents for every word touched later
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 18; i++) begin
        w = (i < 16) ? 8'(8'h40 + i) : 8'(8'h80 + i - 16);
        send(g, 3'd1, 8'($urandom), {22'd0, w, 2'b00}, 2'd0, $urandom, 0, 1'b0, 32'd0);
      end
    end

    // zero latency: word write/read, subword, boundary, aliasing, unsupported type
    send(0, 3'd1, 8'h12, 32'h100, 2'd0, 32'hDEADBEEF, 0, 1'b1, 32'h0);
    send(0, 3'd0, 8'h13, 32'h100, 2'd0, $urandom, 0, 1'b1, 32'hDEADBEEF);
    send(0, 3'd1, 8'h14, 32'h102, 2'd1, 32'h000000AA, 0, 1'b1, 32'h0);
    send(0, 3'd0, 8'h15, 32'h100, 2'd0, $urandom, 0, 1'b1, 32'hDEAABEEF);
    send(0, 3'd0, 8'h16, 32'h102, 2'd2, $urandom, 0, 1'b1, 32'h0000DEAA);
    w104 = model_word(0, 8'h41);
    send(0, 3'd1, 8'h17, 32'h103, 2'd2, 32'h00001122, 0, 1'b1, 32'h0);
    send(0, 3'd0, 8'h18, 32'h100, 2'd0, $urandom, 0, 1'b1, 32'h22AABEEF);
    send(0, 3'd0, 8'h19, 32'h104, 2'd0, $urandom, 0, 1'b1, w104);
    send(0, 3'd0, 8'h1A, 32'h100 + 4 * NW, 2'd0, $urandom, 0, 1'b1, 32'h22AABEEF);
    send(0, 3'd3, 8'h1B, 32'h100, 2'd0, 32'h00000055, 0, 1'b1, 32'h0);
    send(0, 3'd0, 8'h1C, 32'h100, 2'd0, $urandom, 0, 1'b1, 32'h22AABEEF);

    // latency 3 with 5 cycles of response backpressure
    send(1, 3'd1, 8'h21, 32'h108, 2'd0, 32'hCAFEF00D, 5, 1'b1, 32'h0);
    send(1, 3'd0, 8'h22, 32'h108, 2'd0, $urandom, 5, 1'b1, 32'hCAFEF00D);

    // latency 5, reset two cycles after accepting a write to 0x200
    prior = model_word(2, 8'h80);
    issue(2, 3'd1, 8'h31, 32'h200, 2'd0, ~prior, 1'b1, 1'b0, 32'h0, 1'b1, ok);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("resp_val_async_reset", 64'(resp_val[2]), 64'd0);
    chk("req_rdy_in_reset", 64'(req_rdy[2]), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("req_rdy_after_release_dut%0d", g), 64'(req_rdy[g]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_resp_after_reset", 64'(resp_val[2]), 64'd0);
    end
    resp_rdy[2] = 1'b0;
    send(2, 3'd0, 8'h32, 32'h200, 2'd0, $urandom, 0, 1'b1, prior);

    // randomized traffic over the initialised words, with random alias bits
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 40; k++) begin
        w = 8'(8'h40 + $urandom_range(15));
        a = $urandom;
        a = {a[31:10], w, 2'($urandom_range(3))};
        r = int'($urandom_range(9));
        t = (r < 4) ? 3'd0 : ((r < 8) ? 3'd1 : 3'($urandom_range(7, 2)));
        send(g, t, 8'($urandom), a, 2'($urandom), $urandom, int'($urandom_range(2)), 1'b0, 32'h0);
      end
    end

    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int g = 0; g < 3; g++)
      chk($sformatf("scoreboard_drained_dut%0d", g), 64'(exp_q[g].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
